// File: rtl/ika9958_dlclk_master.sv
// DHCLK_n/DLCLK_n pair generator for driving a slave VDP's external DLCLK input,
// with one-tick phase slips and a lock monitor on the echoed DLCLK_n.
module ika9958_dlclk_master #(
    parameter int LOCK_CNT = 4
) (
    input  logic i_XTAL1,
    input  logic i_RST_n,
    input  logic i_XTAL_NCEN,
    input  logic i_SLIP,
    input  logic i_DLCLK_RET_n,
    output logic o_DHCLK_n,
    output logic o_DLCLK_n,
    output logic o_DHCLK_FALL,
    output logic o_DHCLK_RISE,
    output logic o_DLCLK_FALL,
    output logic o_DLCLK_RISE,
    output logic o_SLIP_BUSY,
    output logic o_LOCKED
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);

    logic [1:0] p_q, p_d;
    logic       pend_q, pend_d;
    logic       held_q, held_d;
    logic [1:0] sync_q, sync_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hold, adv, chk, match, r;

    always_comb begin
        r      = sync_q[1];
        // A slip only lands on the first tick of a p==3 dwell, so back-to-back
        // requests can never stretch the same low phase twice.
        hold   = i_XTAL_NCEN && (p_q == 2'd3) && pend_q && !held_q;
        adv    = i_XTAL_NCEN && !hold;
        p_d    = adv ? p_q + 2'd1 : p_q;
        sync_d = {sync_q[0], i_DLCLK_RET_n};

        pend_d = pend_q;
        if (hold) begin
            pend_d = 1'b0;
        end else if (i_SLIP && !pend_q) begin
            pend_d = 1'b1;
        end

        held_d = held_q;
        if (hold) begin
            held_d = 1'b1;
        end else if (i_XTAL_NCEN) begin
            held_d = 1'b0;
        end

        chk   = adv && p_q[0];
        match = (p_q == 2'd1) ? r : !r;
        cnt_d = cnt_q;
        if (hold || (chk && !match)) begin
            cnt_d = 4'd0;
        end else if (chk && (cnt_q != LOCK_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end

        o_DHCLK_FALL = i_RST_n && adv && !p_q[0];
        o_DHCLK_RISE = i_RST_n && adv && p_q[0];
        o_DLCLK_FALL = i_RST_n && adv && (p_q == 2'd1);
        o_DLCLK_RISE = i_RST_n && adv && (p_q == 2'd3);
    end

    always_ff @(posedge i_XTAL1) begin
        if (!i_RST_n) begin
            p_q    <= 2'd0;
            pend_q <= 1'b0;
            held_q <= 1'b0;
            sync_q <= 2'b11;
            cnt_q  <= 4'd0;
        end else begin
            p_q    <= p_d;
            pend_q <= pend_d;
            held_q <= held_d;
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_DHCLK_n   = ~p_q[0];
    assign o_DLCLK_n   = ~p_q[1];
    assign o_SLIP_BUSY = pend_q;
    assign o_LOCKED    = (cnt_q == LOCK_MAX);

endmodule

// File: tb/tb_ika9958_dlclk_master.sv
// Bench for ika9958_dlclk_master: fixed vectors after reset, scenario sequences,
// then randomized traffic, all cycles compared against a behavioural model.
module tb_ika9958_dlclk_master;

    localparam int LOCK = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ncen, slip, ret;
    logic dh, dl, dhf, dhr, dlf, dlr, busy, locked;
    int   ret_mode;
    logic force_val;

    assign ret = (ret_mode == 0) ? dl : (ret_mode == 1) ? ~dl : force_val;

    ika9958_dlclk_master #(.LOCK_CNT(LOCK)) dut (
        .i_XTAL1(clk), .i_RST_n(rst_n), .i_XTAL_NCEN(ncen), .i_SLIP(slip),
        .i_DLCLK_RET_n(ret), .o_DHCLK_n(dh), .o_DLCLK_n(dl),
        .o_DHCLK_FALL(dhf), .o_DHCLK_RISE(dhr), .o_DLCLK_FALL(dlf), .o_DLCLK_RISE(dlr),
        .o_SLIP_BUSY(busy), .o_LOCKED(locked)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase index into the output sequence, slip bookkeeping,
    // synchroniser pipeline and the match counter.
    bit [1:0] seq [4];
    int       m_ph, m_c;
    bit       m_pend, m_held;
    bit [1:0] m_sync;

    bit       obs_dh, obs_dl, obs_busy, obs_lock;
    bit [3:0] obs_stb;
    bit       slip_lvl;

    typedef struct {
        bit       rn;
        bit       n;
        bit [1:0] o;     // {DLCLK_n, DHCLK_n}
        bit [3:0] stb;   // {DH fall, DH rise, DL fall, DL rise}
        bit       b;
        bit       l;
    } vec_t;
    vec_t vt [18];

    function automatic vec_t mk(input bit rn, input bit n, input bit [1:0] o, input bit [3:0] stb);
        vec_t v;
        v.rn = rn; v.n = n; v.o = o; v.stb = stb; v.b = 1'b0; v.l = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_c = 0; m_pend = 0; m_held = 0; m_sync = 2'b11;
    endtask

    // One XTAL1 cycle: drive at the falling edge, compare, then advance the model.
    task automatic cyc(input bit n, input bit s, input bit rn);
        bit [1:0] cur, nxt;
        int       nph;
        bit       tk, hold, r, match, ret_s;
        ncen = n; slip = s; rst_n = rn;
        #1;
        cur  = seq[m_ph];
        tk   = n && rn;
        hold = tk && (m_ph == 3) && m_pend && !m_held;
        nph  = (tk && !hold) ? (m_ph + 1) % 4 : m_ph;
        nxt  = seq[nph];
        chk("dhclk_n", dh, cur[0]);
        chk("dlclk_n", dl, cur[1]);
        chk("dh_fall", dhf, cur[0] & ~nxt[0]);
        chk("dh_rise", dhr, ~cur[0] & nxt[0]);
        chk("dl_fall", dlf, cur[1] & ~nxt[1]);
        chk("dl_rise", dlr, ~cur[1] & nxt[1]);
        chk("slip_busy", busy, m_pend);
        chk("locked", locked, m_c == LOCK);
        obs_dh = dh; obs_dl = dl; obs_busy = busy; obs_lock = locked;
        obs_stb = {dhf, dhr, dlf, dlr};
        ret_s = ret;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            r = m_sync[1];
            m_sync = {m_sync[0], ret_s};
            if (hold) begin
                m_c = 0; m_pend = 0; m_held = 1;
            end else begin
                if (tk) m_held = 0;
                if (tk && (m_ph == 1 || m_ph == 3)) begin
                    match = (m_ph == 1) ? r : !r;
                    m_c = match ? ((m_c < LOCK) ? m_c + 1 : LOCK) : 0;
                end
                if (s && !m_pend) m_pend = 1;
            end
            m_ph = nph;
        end
        @(negedge clk);
    endtask

    task automatic tick4(input bit s_tick);
        repeat (3) cyc(1'b0, slip_lvl, 1'b1);
        cyc(1'b1, slip_lvl | s_tick, 1'b1);
    endtask

    task automatic checks_to_lock(output int nchk);
        nchk = -1;
        for (int t = 0, k = 0; t < 24 && nchk < 0; t++) begin
            if (m_ph == 1 || m_ph == 3) k++;
            tick4(1'b0);
            if (locked) nchk = k;
        end
    endtask

    initial begin
        int lock_at, lowcnt, busy_t, held, held_t, dl_low, fall_t, relock, consec, hi, nchk, gap;
        bit h, prevheld;
        seq = '{2'b11, 2'b10, 2'b01, 2'b00};
        ret_mode = 0; force_val = 1'b0; slip_lvl = 1'b0;
        rst_n = 1'b0; ncen = 1'b0; slip = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset followed by free-run, NCEN every 4 cycles.
        vt[0]  = mk(0, 0, 2'b11, 4'b0000);
        vt[1]  = mk(1, 1, 2'b11, 4'b1000);
        vt[2]  = mk(1, 0, 2'b10, 4'b0000);
        vt[3]  = mk(1, 0, 2'b10, 4'b0000);
        vt[4]  = mk(1, 0, 2'b10, 4'b0000);
        vt[5]  = mk(1, 1, 2'b10, 4'b0110);
        vt[6]  = mk(1, 0, 2'b01, 4'b0000);
        vt[7]  = mk(1, 0, 2'b01, 4'b0000);
        vt[8]  = mk(1, 0, 2'b01, 4'b0000);
        vt[9]  = mk(1, 1, 2'b01, 4'b1000);
        vt[10] = mk(1, 0, 2'b00, 4'b0000);
        vt[11] = mk(1, 0, 2'b00, 4'b0000);
        vt[12] = mk(1, 0, 2'b00, 4'b0000);
        vt[13] = mk(1, 1, 2'b00, 4'b0101);
        vt[14] = mk(1, 0, 2'b11, 4'b0000);
        vt[15] = mk(1, 0, 2'b11, 4'b0000);
        vt[16] = mk(1, 0, 2'b11, 4'b0000);
        vt[17] = mk(1, 1, 2'b11, 4'b1000);
        for (int i = 0; i < 18; i++) begin
            cyc(vt[i].n, 1'b0, vt[i].rn);
            chk_int($sformatf("vec%0d_out", i), {obs_dl, obs_dh}, vt[i].o);
            chk_int($sformatf("vec%0d_stb", i), obs_stb, vt[i].stb);
            chk($sformatf("vec%0d_busy", i), obs_busy, vt[i].b);
            chk($sformatf("vec%0d_lock", i), obs_lock, vt[i].l);
        end

        // Loopback lock from reset, then hold for 1000 ticks.
        cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
        lock_at = 0;
        for (int t = 1; t <= 20; t++) begin
            tick4(1'b0);
            if (locked && lock_at == 0) lock_at = t;
        end
        chk_int("lock_ticks", lock_at, 2 * LOCK);
        lowcnt = 0;
        for (int t = 0; t < 1000; t++) begin
            tick4(1'b0);
            if (!locked) lowcnt++;
        end
        chk_int("lock_hold", lowcnt, 0);

        // Single slip requested on the p==1 tick.
        for (int k = 0; k < 4 && m_ph != 1; k++) tick4(1'b0);
        tick4(1'b1);
        busy_t = 0; held = 0; held_t = -1; dl_low = 0; fall_t = -1; relock = -1;
        for (int t = 1; t <= 14; t++) begin
            tick4(1'b0);
            if (obs_busy) busy_t++;
            if (obs_stb == 4'b0000) begin
                held++; held_t = t;
                chk("lock_drop", locked, 1'b0);
            end
            if (t <= 4 && !obs_dl) dl_low++;
            if (obs_stb[1] && fall_t < 0) fall_t = t;
            if (held_t > 0 && locked && relock < 0) relock = t - held_t;
        end
        chk_int("slip_busy_ticks", busy_t, 2);
        chk_int("slip_held_ticks", held, 1);
        chk_int("slip_dl_low", dl_low, 3);
        chk_int("slip_period", fall_t, 5);
        chk_int("slip_relock", relock, 7);

        // Slip request held high for 20 ticks.
        slip_lvl = 1'b1; held = 0; consec = 0; prevheld = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick4(1'b0);
            h = (obs_stb == 4'b0000);
            if (h && prevheld) consec++;
            if (h) held++;
            prevheld = h;
        end
        slip_lvl = 1'b0;
        chk_int("slip_cont_consec", consec, 0);
        chk_int("slip_cont_count", held, 4);

        // Inverted return path never locks; restoring it relocks in LOCK checks.
        ret_mode = 1; hi = 0;
        for (int t = 0; t < 40; t++) begin
            tick4(1'b0);
            if (t >= 2 && locked) hi++;
        end
        chk_int("inv_locked", hi, 0);
        ret_mode = 0;
        checks_to_lock(nchk);
        chk_int("restore_checks", nchk, LOCK);

        // One forced-wrong check at p==1.
        for (int k = 0; k < 4 && m_ph != 0; k++) tick4(1'b0);
        ret_mode = 2; force_val = 1'b0;
        tick4(1'b0);
        tick4(1'b0);
        ret_mode = 0;
        chk("wrong_check_unlock", locked, 1'b0);
        checks_to_lock(nchk);
        chk_int("wrong_check_relock", nchk, LOCK);

        // Reset while a slip is in flight.
        cyc(1'b0, 1'b1, 1'b1);
        chk("midslip_busy", busy, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("midslip_rst_busy", busy, 1'b0);
        chk("midslip_rst_dl", dl, 1'b1);
        chk("midslip_rst_dh", dh, 1'b1);
        chk("midslip_rst_lock", locked, 1'b0);
        held = 0;
        for (int t = 0; t < 8; t++) begin
            tick4(1'b0);
            if (obs_stb == 4'b0000) held++;
        end
        chk_int("midslip_no_hold", held, 0);

        // Randomized traffic with varying tick spacing, slips, return paths and resets.
        for (int i = 0; i < 500; i++) begin
            gap = $urandom_range(3, 6);
            if ($urandom_range(0, 15) == 0) begin
                ret_mode  = $urandom_range(0, 2);
                force_val = 1'($urandom_range(0, 1));
            end
            for (int j = 0; j < gap - 1; j++)
                cyc(1'b0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0);
            cyc(1'b1, $urandom_range(0, 7) == 0, 1'b1);
        end
        ret_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
